rgb_pwm_ctrl: RTL

RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

---
 rtl/rgb_pwm_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rgb_pwm_ctrl.sv
// Three-channel RGB PWM controller with a prescaled period counter, an
// OFF/RUN/DRAIN run-state machine and a single-entry duty write slot whose
// contents are applied only at a period wrap while running (glitch-free update).
module rgb_pwm_ctrl #(
   parameter int unsigned CtrWidth = 8,
   parameter int unsigned PreWidth = 16
) (
   input  logic                clk_sys_i,
   input  logic                rst_sys_ni,
   input  logic                enable_i,
   input  logic [PreWidth-1:0] prescale_i,
   input  logic                cfg_valid_i,
   output logic                cfg_ready_o,
   input  logic [1:0]          cfg_ch_i,
   input  logic [CtrWidth-1:0] cfg_duty_i,
   output logic [2:0]          pwm_o,
   output logic                period_o,
   output logic                busy_o
);

   typedef enum logic [1:0] {StOff, StRun, StDrain} state_e;

   localparam logic [CtrWidth-1:0] CtrMax = '1;

   state_e                    state_q, state_d;
   logic [CtrWidth-1:0]       ctr_q, ctr_d;
   logic [PreWidth-1:0]       pre_cnt_q, pre_cnt_d;
   logic [PreWidth-1:0]       pre_lat_q, pre_lat_d;
   logic [2:0][CtrWidth-1:0]  duty_q, duty_d;
   logic                      slot_full_q, slot_full_d;
   logic [1:0]                slot_ch_q, slot_ch_d;
   logic [CtrWidth-1:0]       slot_duty_q, slot_duty_d;
   logic [2:0]                pwm_q, pwm_d;
   logic                      period_q, period_d;

   logic active, tick, wrap, accept, apply;

   // Next-state logic: run FSM, prescaler/counter, duty slot and output compare.
   always_comb begin
      state_d     = state_q;
      ctr_d       = ctr_q;
      pre_cnt_d   = pre_cnt_q;
      pre_lat_d   = pre_lat_q;
      duty_d      = duty_q;
      slot_full_d = slot_full_q;
      slot_ch_d   = slot_ch_q;
      slot_duty_d = slot_duty_q;
      pwm_d       = '0;

      active = (state_q != StOff);
      tick   = active && (pre_cnt_q == '0);
      wrap   = tick && (ctr_q == CtrMax);
      accept = cfg_valid_i && !slot_full_q;
      // While running, the slot only lands at a wrap so a period never sees a duty change.
      apply  = slot_full_q && (!active || wrap);

      period_d = wrap;

      unique case (state_q)
         StOff: begin
            // Keep tracking prescale_i so the value present on entry is the one used.
            pre_lat_d = prescale_i;
            pre_cnt_d = prescale_i;
            ctr_d     = '0;
            if (enable_i) state_d = StRun;
         end
         StRun, StDrain: begin
            if (tick) begin
               pre_cnt_d = pre_lat_q;
               ctr_d     = ctr_q + 1'b1;
            end else begin
               pre_cnt_d = pre_cnt_q - 1'b1;
            end
            for (int c = 0; c < 3; c++) pwm_d[c] = (ctr_q < duty_q[c]);
            if (enable_i)               state_d = StRun;
            else if (state_q == StRun)  state_d = StDrain;
            else if (wrap)              state_d = StOff;
         end
         default: state_d = StOff;
      endcase

      if (apply) begin
         slot_full_d = 1'b0;
         // Channel 3 matches no index and is silently dropped.
         for (int c = 0; c < 3; c++) begin
            if (slot_ch_q == 2'(c)) duty_d[c] = slot_duty_q;
         end
      end
      if (accept) begin
         slot_full_d = 1'b1;
         slot_ch_d   = cfg_ch_i;
         slot_duty_d = cfg_duty_i;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         state_q     <= StOff;
         ctr_q       <= '0;
         pre_cnt_q   <= '0;
         pre_lat_q   <= '0;
         duty_q      <= '0;
         slot_full_q <= 1'b0;
         slot_ch_q   <= '0;
         slot_duty_q <= '0;
         pwm_q       <= '0;
         period_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctr_q       <= ctr_d;
         pre_cnt_q   <= pre_cnt_d;
         pre_lat_q   <= pre_lat_d;
         duty_q      <= duty_d;
         slot_full_q <= slot_full_d;
         slot_ch_q   <= slot_ch_d;
         slot_duty_q <= slot_duty_d;
         pwm_q       <= pwm_d;
         period_q    <= period_d;
      end
   end

   assign cfg_ready_o = !slot_full_q;
   assign pwm_o       = pwm_q;
   assign period_o    = period_q;
   assign busy_o      = (state_q != StOff);

endmodule
